// File: rtl/edge_pkg.sv
// Shared types and width helpers for the 3x3 streaming edge filter.
package edge_pkg;

  typedef enum logic {
    KERN_SOBEL   = 1'b0,
    KERN_PREWITT = 1'b1
  } kernel_e;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Signed gradient accumulator: four pixels of headroom plus sign.
  function automatic int unsigned acc_width(input int unsigned pix_w);
    return pix_w + 4;
  endfunction

  function automatic int unsigned sat_value(input int unsigned pix_w);
    return (32'd1 << pix_w) - 32'd1;
  endfunction

endpackage

// File: rtl/line_window_3x3.sv
// Two-line-plus-two-pixel shift buffer; with the live pixel it forms a 3x3 window.
module line_window_3x3 #(
  parameter int unsigned IMG_WIDTH = 720,
  parameter int unsigned PIX_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  shift_en,
  input  logic [PIX_W-1:0]      pixel_in,
  output logic [8:0][PIX_W-1:0] taps
);

  localparam int unsigned DEPTH = 2 * IMG_WIDTH + 2;

  // r_line[k] holds the pixel consumed k+1 pops ago.
  logic [DEPTH-1:0][PIX_W-1:0] r_line;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_line <= '0;
    end else if (shift_en) begin
      r_line <= {r_line[DEPTH-2:0], pixel_in};
    end
  end

  // Row-major taps: index 0 is top-left, 8 is bottom-right (the live pixel).
  assign taps[0] = r_line[2*IMG_WIDTH+1];
  assign taps[1] = r_line[2*IMG_WIDTH];
  assign taps[2] = r_line[2*IMG_WIDTH-1];
  assign taps[3] = r_line[IMG_WIDTH+1];
  assign taps[4] = r_line[IMG_WIDTH];
  assign taps[5] = r_line[IMG_WIDTH-1];
  assign taps[6] = r_line[1];
  assign taps[7] = r_line[0];
  assign taps[8] = pixel_in;

endmodule

// File: rtl/edge_filter_3x3.sv
// Streaming 3x3 Sobel/Prewitt edge detector between the gray FIFO and the image-out FIFO.
module edge_filter_3x3 #(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540,
  parameter int unsigned PIX_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             thresh_en,
  input  logic [PIX_W-1:0] threshold,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [PIX_W-1:0] in_dout,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [PIX_W-1:0] out_din,
  output logic             busy,
  output logic             done
);

  import edge_pkg::*;

  localparam int unsigned ACC_W = acc_width(PIX_W);
  localparam int unsigned SAT_U = sat_value(PIX_W);
  localparam int unsigned XW    = $clog2(IMG_WIDTH);
  localparam int unsigned YW    = $clog2(IMG_HEIGHT);
  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(SAT_U);

  state_e           r_state;
  state_e           w_next_state;
  logic             w_rd_en;
  logic             w_wr_en;
  logic [XW-1:0]    r_in_x;
  logic [YW-1:0]    r_in_y;
  logic [XW-1:0]    r_out_x;
  logic [YW-1:0]    r_out_y;
  kernel_e          r_kernel;
  logic             r_thresh_en;
  logic [PIX_W-1:0] r_threshold;
  logic             r_busy;
  logic             r_done;

  logic w_in_last_col;
  logic w_in_last;
  logic w_out_last_col;
  logic w_out_last;
  logic w_frame_start;
  logic w_frame_end;

  assign w_in_last_col  = (r_in_x == XW'(IMG_WIDTH - 1));
  assign w_in_last      = w_in_last_col && (r_in_y == YW'(IMG_HEIGHT - 1));
  assign w_out_last_col = (r_out_x == XW'(IMG_WIDTH - 1));
  assign w_out_last     = w_out_last_col && (r_out_y == YW'(IMG_HEIGHT - 1));
  assign w_frame_start  = w_rd_en && (r_state == FILL) && (r_in_x == '0) && (r_in_y == '0);
  assign w_frame_end    = w_wr_en && (r_state == FLUSH) && w_out_last;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and FIFO handshakes; reads and writes pair up in RUN.
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    if (!reset) begin
      case (r_state)
        FILL: begin
          w_rd_en = !in_empty;
          if (w_rd_en && (r_in_x == '0) && (r_in_y == YW'(1))) begin
            w_next_state = RUN;
          end
        end
        RUN: begin
          w_rd_en = !in_empty && !out_full;
          w_wr_en = w_rd_en;
          if (w_rd_en && w_in_last) begin
            w_next_state = FLUSH;
          end
        end
        FLUSH: begin
          w_wr_en = !out_full;
          if (w_wr_en && w_out_last) begin
            w_next_state = DONE;
          end
        end
        DONE: begin
          w_next_state = FILL;
        end
      endcase
    end
  end

  // Raster counters for the consumed input and for the pixel being written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_in_x  <= '0;
      r_in_y  <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
    end else begin
      if (w_rd_en) begin
        if (w_in_last_col) begin
          r_in_x <= '0;
          r_in_y <= w_in_last ? '0 : r_in_y + YW'(1);
        end else begin
          r_in_x <= r_in_x + XW'(1);
        end
      end
      if (w_wr_en) begin
        if (w_out_last_col) begin
          r_out_x <= '0;
          r_out_y <= w_out_last ? '0 : r_out_y + YW'(1);
        end else begin
          r_out_x <= r_out_x + XW'(1);
        end
      end
    end
  end

  // Frame configuration and status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_kernel    <= KERN_SOBEL;
      r_thresh_en <= 1'b0;
      r_threshold <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      if (w_frame_start) begin
        r_kernel    <= kernel_e'(mode);
        r_thresh_en <= thresh_en;
        r_threshold <= threshold;
        r_busy      <= 1'b1;
      end else if (w_frame_end) begin
        r_busy <= 1'b0;
      end
    end
  end

  logic [8:0][PIX_W-1:0] w_taps;

  line_window_3x3 #(
    .IMG_WIDTH (IMG_WIDTH),
    .PIX_W     (PIX_W)
  ) u_window (
    .clock    (clock),
    .reset    (reset),
    .shift_en (w_rd_en),
    .pixel_in (in_dout),
    .taps     (w_taps)
  );

  // The centre tap carries zero weight in both kernels.
  logic w_unused_centre;
  assign w_unused_centre = ^w_taps[4];

  function automatic logic signed [ACC_W-1:0] weigh(input logic signed [ACC_W-1:0] v,
                                                    input kernel_e                  k);
    return (k == KERN_SOBEL) ? (v <<< 1) : v;
  endfunction

  logic signed [ACC_W-1:0] w_t [9];
  logic signed [ACC_W-1:0] w_gx;
  logic signed [ACC_W-1:0] w_gy;
  logic [ACC_W-1:0]        w_abs_gx;
  logic [ACC_W-1:0]        w_abs_gy;
  logic [ACC_W-1:0]        w_mag;
  logic [PIX_W-1:0]        w_mag_sat;
  logic [PIX_W-1:0]        w_pix;
  logic                    w_border;

  always_comb begin
    for (int n = 0; n < 9; n++) begin
      w_t[n] = signed'(ACC_W'(w_taps[n]));
    end
    w_gx = (w_t[2] + weigh(w_t[5], r_kernel) + w_t[8])
         - (w_t[0] + weigh(w_t[3], r_kernel) + w_t[6]);
    w_gy = (w_t[6] + weigh(w_t[7], r_kernel) + w_t[8])
         - (w_t[0] + weigh(w_t[1], r_kernel) + w_t[2]);
    w_abs_gx  = w_gx[ACC_W-1] ? ACC_W'(-w_gx) : ACC_W'(w_gx);
    w_abs_gy  = w_gy[ACC_W-1] ? ACC_W'(-w_gy) : ACC_W'(w_gy);
    w_mag     = (w_abs_gx + w_abs_gy) >> 1;
    w_mag_sat = (w_mag > ACC_W'(PIX_MAX)) ? PIX_MAX : w_mag[PIX_W-1:0];
    w_pix     = r_thresh_en ? ((w_mag_sat >= r_threshold) ? PIX_MAX : '0) : w_mag_sat;
  end

  assign w_border = (r_out_y == '0) || (r_out_y == YW'(IMG_HEIGHT - 1))
                 || (r_out_x == '0) || (r_out_x == XW'(IMG_WIDTH - 1));

  // Flush writes and border pixels are zero.
  assign out_din   = ((r_state == RUN) && !w_border) ? w_pix : '0;
  assign in_rd_en  = w_rd_en;
  assign out_wr_en = w_wr_en;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_edge_filter_3x3.sv
// Scoreboard bench for edge_filter_3x3 on a 4x4 frame with emulated FIFOs.
module tb_edge_filter_3x3;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int PW   = 8;
  localparam int N    = W * H;
  localparam int MAXV = 255;

  logic          clock = 1'b0;
  logic          reset;
  logic          mode;
  logic          thresh_en;
  logic [PW-1:0] threshold;
  logic          in_rd_en;
  logic          in_empty;
  logic [PW-1:0] in_dout;
  logic          out_wr_en;
  logic          out_full;
  logic [PW-1:0] out_din;
  logic          busy;
  logic          done;

  int in_q[$];
  int exp_q[$];
  int n_tests  = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_done   = 0;
  int n_pops   = 0;
  bit stall_en = 1'b0;
  logic prev_busy = 1'b0;

  edge_filter_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (PW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .thresh_en (thresh_en),
    .threshold (threshold),
    .in_rd_en  (in_rd_en),
    .in_empty  (in_empty),
    .in_dout   (in_dout),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .out_din   (out_din),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // kind 0: constant hi; 1: columns 0-1 = 0, columns 2-3 = hi; else random.
  task automatic push_frame(input int kind, input int hi, input bit m, input bit te, input int th);
    int pix[N];
    int k, gx, gy, mag, e;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       pix[i] = hi;
        1:       pix[i] = ((i % W) >= 2) ? hi : 0;
        default: pix[i] = int'($urandom_range(0, MAXV));
      endcase
      in_q.push_back(pix[i]);
    end
    k = m ? 1 : 2;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        e = 0;
        if (y != 0 && y != H - 1 && x != 0 && x != W - 1) begin
          gx = (pix[(y-1)*W+x+1] + k*pix[y*W+x+1] + pix[(y+1)*W+x+1])
             - (pix[(y-1)*W+x-1] + k*pix[y*W+x-1] + pix[(y+1)*W+x-1]);
          gy = (pix[(y+1)*W+x-1] + k*pix[(y+1)*W+x] + pix[(y+1)*W+x+1])
             - (pix[(y-1)*W+x-1] + k*pix[(y-1)*W+x] + pix[(y-1)*W+x+1]);
          if (gx < 0) gx = -gx;
          if (gy < 0) gy = -gy;
          mag = (gx + gy) / 2;
          if (mag > MAXV) mag = MAXV;
          e = te ? ((mag >= th) ? MAXV : 0) : mag;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive();
    in_empty = (in_q.size() == 0) || (stall_en && $urandom_range(0, 2) == 0);
    in_dout  = (in_q.size() != 0) ? PW'(in_q[0]) : '0;
    out_full = stall_en && ($urandom_range(0, 2) == 0);
  endtask

  // Sample on the falling edge, apply FIFO effects just after the rising edge.
  task automatic cycle();
    bit pop;
    @(negedge clock);
    pop = in_rd_en;
    if (in_rd_en) check("rd_while_empty", in_empty, 0);
    if (out_wr_en) begin
      check("wr_while_full", out_full, 0);
      n_writes++;
      check("exp_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check($sformatf("pix%0d", n_writes), out_din, exp_q.pop_front());
    end
    if (done) begin
      n_done++;
      check("busy_at_done", {prev_busy, busy}, 2'b10);
    end
    prev_busy = busy;
    @(posedge clock);
    #1;
    if (pop) begin
      void'(in_q.pop_front());
      n_pops++;
    end
    drive();
  endtask

  task automatic run(input int exp_writes, input int exp_done, input int flip_at);
    int cyc = 0;
    n_writes = 0;
    n_done   = 0;
    n_pops   = 0;
    drive();
    while ((exp_q.size() != 0 || in_q.size() != 0) && cyc < 5000) begin
      cycle();
      cyc++;
      if (flip_at >= 0 && n_pops == flip_at) mode = 1'b1;
    end
    check("drained", exp_q.size(), 0);
    repeat (4) cycle();
    check("writes", n_writes, exp_writes);
    check("done_pulses", n_done, exp_done);
  endtask

  initial begin
    int cyc;
    reset     = 1'b1;
    mode      = 1'b0;
    thresh_en = 1'b0;
    threshold = '0;
    in_empty  = 1'b0;
    out_full  = 1'b0;
    in_dout   = 8'd55;
    repeat (2) @(negedge clock);
    check("rst_rd_en", in_rd_en, 0);
    check("rst_wr_en", out_wr_en, 0);
    check("rst_out_din", out_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive();

    push_frame(0, 100, 0, 0, 0);
    run(N, 1, -1);

    push_frame(1, 20, 0, 0, 0);
    run(N, 1, -1);
    mode = 1'b1;
    push_frame(1, 20, 1, 0, 0);
    run(N, 1, -1);

    thresh_en = 1'b1;
    threshold = 8'd35;
    mode      = 1'b0;
    push_frame(1, 20, 0, 1, 35);
    run(N, 1, -1);
    mode = 1'b1;
    push_frame(1, 20, 1, 1, 35);
    run(N, 1, -1);
    thresh_en = 1'b0;
    threshold = '0;

    stall_en = 1'b1;
    mode     = 1'b0;
    push_frame(1, 255, 0, 0, 0);
    run(N, 1, -1);
    push_frame(2, 0, 0, 0, 0);
    run(N, 1, -1);
    mode = 1'b1;
    push_frame(2, 0, 1, 0, 0);
    run(N, 1, -1);

    mode = 1'b0;
    push_frame(2, 0, 0, 0, 0);
    push_frame(2, 0, 1, 0, 0);
    run(2 * N, 2, 3);
    mode = 1'b0;

    push_frame(2, 0, 0, 0, 0);
    n_pops   = 0;
    n_writes = 0;
    cyc      = 0;
    drive();
    while (n_pops < 7 && cyc < 500) begin
      cycle();
      cyc++;
    end
    check("pops_before_reset", n_pops, 7);
    reset = 1'b1;
    in_q.delete();
    exp_q.delete();
    drive();
    repeat (2) cycle();
    reset = 1'b0;
    push_frame(2, 0, 0, 0, 0);
    run(N, 1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
